// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for the pong core: attract, serve countdown, play, pause and game over.
// Optional feature macro: PONG_AUTOSTART_EN (idle autostart out of ATTRACT).
module pong_match_ctrl #(
    parameter int WIN_SCORE      = 5,
    parameter int COUNT_STEPS    = 3,
    parameter int STEP_FRAMES    = 60,
    parameter int OVER_FRAMES    = 180,
    parameter int FRAME_DIV      = 1,
    parameter int ATTRACT_FRAMES = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       btn_start,
    input  logic [3:0] score_l,
    input  logic [3:0] score_r,
    output logic       tick,
    output logic       core_rst,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        ST_ATTRACT   = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_OVER      = 3'd4
    } match_state_t;

    localparam logic [3:0] WIN       = 4'(WIN_SCORE);
    localparam logic [1:0] STEPS     = 2'(COUNT_STEPS);
    localparam logic [9:0] STEP_LAST = 10'(STEP_FRAMES - 1);
    localparam logic [9:0] OVER_LAST = 10'(OVER_FRAMES - 1);
    localparam logic [3:0] DIV_LAST  = 4'(FRAME_DIV - 1);

    match_state_t cur_state, nxt_state;
    logic         sync1, sync2, sync3;
    logic         press;
    logic         auto_start;
    logic [9:0]   frame_cnt, nxt_frame;
    logic [3:0]   div_cnt, nxt_div;
    logic [1:0]   nxt_countdown, nxt_winner;
    logic         nxt_tick;

    // sync1/sync2 form the synchronizer; sync3 only delays sync2 for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= btn_start;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign press = sync2 & ~sync3;

`ifdef PONG_AUTOSTART_EN
    localparam logic [9:0] ATTRACT_LAST = 10'(ATTRACT_FRAMES - 1);
    assign auto_start = frame_start && (frame_cnt == ATTRACT_LAST);
`else
    assign auto_start = 1'b0;
`endif

    always_comb begin
        nxt_state     = cur_state;
        nxt_countdown = countdown;
        nxt_winner    = winner;
        nxt_frame     = frame_start ? frame_cnt + 10'd1 : frame_cnt;
        nxt_div       = div_cnt;
        nxt_tick      = 1'b0;
        case (cur_state)
            ST_ATTRACT: begin
                if (press || auto_start) begin
                    nxt_state     = ST_COUNTDOWN;
                    nxt_countdown = STEPS;
                    nxt_winner    = 2'b00;
                end
            end
            ST_COUNTDOWN: begin
                if (frame_start && frame_cnt == STEP_LAST) begin
                    nxt_frame     = 10'd0;
                    nxt_countdown = countdown - 2'd1;
                    if (countdown == 2'd1) nxt_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // win outranks press, and either one swallows a tick due this cycle
                if (score_l >= WIN) begin
                    nxt_state  = ST_OVER;
                    nxt_winner = 2'b01;
                end else if (score_r >= WIN) begin
                    nxt_state  = ST_OVER;
                    nxt_winner = 2'b10;
                end else if (press) begin
                    nxt_state = ST_PAUSE;
                end else if (frame_start) begin
                    if (div_cnt == DIV_LAST) begin
                        nxt_div  = 4'd0;
                        nxt_tick = 1'b1;
                    end else begin
                        nxt_div = div_cnt + 4'd1;
                    end
                end
            end
            ST_PAUSE: begin
                if (press) begin
                    nxt_state     = ST_COUNTDOWN;
                    nxt_countdown = STEPS;
                    nxt_winner    = 2'b00;
                end
            end
            ST_OVER: begin
                if (press || (frame_start && frame_cnt == OVER_LAST)) nxt_state = ST_ATTRACT;
            end
            default: nxt_state = ST_ATTRACT;
        endcase
        if (nxt_state != cur_state) begin
            nxt_frame = 10'd0;
            nxt_div   = 4'd0;
        end
        if (nxt_state != ST_COUNTDOWN) nxt_countdown = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_ATTRACT;
            frame_cnt <= 10'd0;
            div_cnt   <= 4'd0;
            countdown <= 2'd0;
            winner    <= 2'b00;
            tick      <= 1'b0;
            core_rst  <= 1'b1;
        end else begin
            cur_state <= nxt_state;
            frame_cnt <= nxt_frame;
            div_cnt   <= nxt_div;
            countdown <= nxt_countdown;
            winner    <= nxt_winner;
            tick      <= nxt_tick;
            core_rst  <= (nxt_state == ST_ATTRACT);
        end
    end

    assign state = cur_state;

endmodule
